// File: rtl/md5core_block_loader.sv
`default_nettype none
// ============================================================================
// Module      : md5core_block_loader
// Description : Pops 16-word blocks from an upstream FWFT FIFO and writes them
//               into the md5 core's 4-slot input buffer, assigning slots in
//               strict round-robin order and gating each block start on the
//               target slot's ready flag. Word 15 carries set_input_ready and
//               the block operation captured with word 0.
//               Optional statistics counters: define MD5_LOADER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module md5core_block_loader #(
  parameter int BLK_OP_MSB = 3
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [31:0]           src_data,
  input  logic [BLK_OP_MSB:0]   src_blk_op,
  input  logic                  src_empty,
  output logic                  src_rd_en,
  input  logic [3:0]            core_ready,
  output logic                  wr_en,
  output logic [31:0]           din,
  output logic [3:0]            wr_addr,
  output logic                  input_ctx,
  output logic                  input_seq,
  output logic [BLK_OP_MSB:0]   input_blk_op,
  output logic                  set_input_ready
`ifdef MD5_LOADER_STATS_EN
  ,
  output logic [15:0]           blk_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [BLK_OP_MSB:0] blk_op_q, blk_op_d;
  logic                wr_en_q, wr_en_d;
  logic [31:0]         din_q, din_d;
  logic [3:0]          wr_addr_q, wr_addr_d;
  logic                input_ctx_q, input_ctx_d;
  logic                input_seq_q, input_seq_d;
  logic [BLK_OP_MSB:0] input_blk_op_q, input_blk_op_d;
  logic                set_input_ready_q, set_input_ready_d;

  logic                slot_ready;
  logic                pop;

  // Ready flags are indexed {ctx,seq}, while the pointer is {seq,ctx}.
  assign slot_ready = core_ready[{ptr_q[0], ptr_q[1]}];

  // Pop only when data is present and either a block is in flight or the
  // next slot in rotation can accept a new block; never while in reset.
  assign pop       = ~rst & ~src_empty & ((state_q == LOAD) | slot_ready);
  assign src_rd_en = pop;

  // Next-state, slot/word bookkeeping and registered write port contents.
  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    wcnt_d            = wcnt_q;
    blk_op_d          = blk_op_q;
    wr_en_d           = 1'b0;
    din_d             = din_q;
    wr_addr_d         = wr_addr_q;
    input_ctx_d       = input_ctx_q;
    input_seq_d       = input_seq_q;
    input_blk_op_d    = input_blk_op_q;
    set_input_ready_d = 1'b0;

    if (pop) begin
      wr_en_d     = 1'b1;
      din_d       = src_data;
      wr_addr_d   = wcnt_q;
      input_ctx_d = ptr_q[0];
      input_seq_d = ptr_q[1];

      if (state_q == IDLE) begin
        // Word 0: the block op is only valid alongside this word.
        blk_op_d = src_blk_op;
        wcnt_d   = 4'd1;
        state_d  = LOAD;
      end else if (wcnt_q == 4'd15) begin
        set_input_ready_d = 1'b1;
        input_blk_op_d    = blk_op_q;
        ptr_d             = ptr_q + 2'd1;
        wcnt_d            = 4'd0;
        state_d           = IDLE;
      end else begin
        wcnt_d = wcnt_q + 4'd1;
      end
    end
  end

  // State and output registers; reset abandons any partial block.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      ptr_q             <= 2'd0;
      wcnt_q            <= 4'd0;
      blk_op_q          <= '0;
      wr_en_q           <= 1'b0;
      din_q             <= 32'd0;
      wr_addr_q         <= 4'd0;
      input_ctx_q       <= 1'b0;
      input_seq_q       <= 1'b0;
      input_blk_op_q    <= '0;
      set_input_ready_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      ptr_q             <= ptr_d;
      wcnt_q            <= wcnt_d;
      blk_op_q          <= blk_op_d;
      wr_en_q           <= wr_en_d;
      din_q             <= din_d;
      wr_addr_q         <= wr_addr_d;
      input_ctx_q       <= input_ctx_d;
      input_seq_q       <= input_seq_d;
      input_blk_op_q    <= input_blk_op_d;
      set_input_ready_q <= set_input_ready_d;
    end
  end

  assign wr_en           = wr_en_q;
  assign din             = din_q;
  assign wr_addr         = wr_addr_q;
  assign input_ctx       = input_ctx_q;
  assign input_seq       = input_seq_q;
  assign input_blk_op    = input_blk_op_q;
  assign set_input_ready = set_input_ready_q;

`ifdef MD5_LOADER_STATS_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters: completed blocks and cycles held for a busy slot.
  always_comb begin
    blk_cnt_d   = blk_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (set_input_ready_d && (blk_cnt_q != 16'hFFFF)) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
    if ((state_q == IDLE) && ~src_empty && ~slot_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      blk_cnt_q   <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      blk_cnt_q   <= blk_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign blk_cnt   = blk_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_md5core_block_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_md5core_block_loader
// Description : Self-checking bench for md5core_block_loader. A queue-based
//               source FIFO feeds the loader; a block/word-position model
//               predicts every pop and the write that follows it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md5core_block_loader;

  localparam int OPW = 4;

  logic           CLK;
  logic           rst;
  logic [31:0]    src_data;
  logic [OPW-1:0] src_blk_op;
  logic           src_empty;
  logic           src_rd_en;
  logic [3:0]     core_ready;
  logic           wr_en;
  logic [31:0]    din;
  logic [3:0]     wr_addr;
  logic           input_ctx;
  logic           input_seq;
  logic [OPW-1:0] input_blk_op;
  logic           set_input_ready;
`ifdef MD5_LOADER_STATS_EN
  logic [15:0]    blk_cnt;
  logic [15:0]    stall_cnt;
`endif

  md5core_block_loader #(.BLK_OP_MSB(OPW-1)) dut (
    .CLK             (CLK),
    .rst             (rst),
    .src_data        (src_data),
    .src_blk_op      (src_blk_op),
    .src_empty       (src_empty),
    .src_rd_en       (src_rd_en),
    .core_ready      (core_ready),
    .wr_en           (wr_en),
    .din             (din),
    .wr_addr         (wr_addr),
    .input_ctx       (input_ctx),
    .input_seq       (input_seq),
    .input_blk_op    (input_blk_op),
    .set_input_ready (set_input_ready)
`ifdef MD5_LOADER_STATS_EN
    ,
    .blk_cnt         (blk_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]    data;
    logic [OPW-1:0] op;
  } word_t;

  word_t fifo[$];
  logic  gap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: block number and word position within the block.
  int             pos;
  int             blk;
  logic [OPW-1:0] cur_op;
  logic           pend_v;
  logic [31:0]    pend_data;
  logic [3:0]     pend_addr;
  logic [1:0]     pend_slot;
  logic           pend_last;
  logic [OPW-1:0] pend_op;
  int             exp_blk;
  int             exp_stall;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    src_empty  = gap || (fifo.size() == 0);
    src_data   = (fifo.size() != 0) ? fifo[0].data : 32'd0;
    src_blk_op = (fifo.size() != 0) ? fifo[0].op : '0;
  endtask

  task automatic push_block(input logic [31:0] base, input logic [OPW-1:0] op);
    for (int i = 0; i < 16; i++) begin
      word_t w;
      w.data = base + 32'(i);
      w.op   = op;
      fifo.push_back(w);
    end
  endtask

  task automatic push_rand_block();
    push_block($urandom, OPW'($urandom));
  endtask

  // One clock cycle: check outputs at negedge, predict the pop, apply it.
  task automatic step();
    logic [1:0] slot;
    logic [1:0] ridx;
    logic       exp_rd;
    drive_inputs();
    @(negedge CLK);
    check_val("wr_en", {31'd0, wr_en}, {31'd0, pend_v});
    if (pend_v) begin
      check_val("din", din, pend_data);
      check_val("wr_addr", {28'd0, wr_addr}, {28'd0, pend_addr});
      check_val("input_ctx", {31'd0, input_ctx}, {31'd0, pend_slot[0]});
      check_val("input_seq", {31'd0, input_seq}, {31'd0, pend_slot[1]});
      check_val("set_input_ready", {31'd0, set_input_ready}, {31'd0, pend_last});
      if (pend_last) begin
        check_val("input_blk_op", 32'(input_blk_op), 32'(pend_op));
        exp_blk++;
      end
    end else begin
      check_val("set_input_ready_idle", {31'd0, set_input_ready}, 32'd0);
    end
`ifdef MD5_LOADER_STATS_EN
    check_val("blk_cnt", {16'd0, blk_cnt}, 32'(exp_blk));
    check_val("stall_cnt", {16'd0, stall_cnt}, 32'(exp_stall));
`endif
    slot   = 2'(blk % 4);
    ridx   = {slot[0], slot[1]};
    exp_rd = !rst && !src_empty && ((pos != 0) || core_ready[ridx]);
    check_val("src_rd_en", {31'd0, src_rd_en}, {31'd0, exp_rd});
    if (!rst && !src_empty && (pos == 0) && !core_ready[ridx]) exp_stall++;
    pend_v = exp_rd;
    if (exp_rd) begin
      if (pos == 0) cur_op = fifo[0].op;
      pend_data = fifo[0].data;
      pend_addr = 4'(pos);
      pend_slot = slot;
      pend_last = (pos == 15);
      pend_op   = cur_op;
      pos++;
      if (pos == 16) begin
        pos = 0;
        blk++;
      end
    end
    @(posedge CLK);
    #1;
    if (exp_rd) void'(fifo.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset from mid-cycle; outputs must clear without a clock.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    check_val("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check_val("rst_set_ready", {31'd0, set_input_ready}, 32'd0);
    check_val("rst_din", din, 32'd0);
    check_val("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check_val("rst_ctx_seq", {30'd0, input_ctx, input_seq}, 32'd0);
    check_val("rst_blk_op", 32'(input_blk_op), 32'd0);
    check_val("rst_src_rd_en", {31'd0, src_rd_en}, 32'd0);
`ifdef MD5_LOADER_STATS_EN
    check_val("rst_blk_cnt", {16'd0, blk_cnt}, 32'd0);
    check_val("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    pos       = 0;
    blk       = 0;
    pend_v    = 1'b0;
    exp_blk   = 0;
    exp_stall = 0;
    run(cycles);
    rst = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((fifo.size() != 0) && (n < limit)) begin
      step();
      n++;
    end
    step();
    check_val("drain_fifo_left", 32'(fifo.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    gap        = 1'b0;
    core_ready = 4'b0000;
    pos = 0; blk = 0; pend_v = 1'b0; exp_blk = 0; exp_stall = 0;
    cur_op = '0; pend_data = '0; pend_addr = '0; pend_slot = '0; pend_last = 1'b0; pend_op = '0;
    drive_inputs();
    @(posedge CLK);
    #1;

    // Two known blocks, all slots ready: 32 back-to-back writes.
    do_reset(2);
    core_ready = 4'b1111;
    push_block(32'h0, 4'h5);
    push_block(32'h10, 4'hA);
    run(36);
    check_val("two_blocks_done", 32'(blk), 32'd2);

    // Slot 1 busy after block 0: loader must hold, then resume.
    do_reset(2);
    core_ready = 4'b1011;
    push_rand_block();
    push_rand_block();
    run(30);
    check_val("held_at_slot1", 32'(blk), 32'd1);
    core_ready = 4'b1111;
    run(20);
    check_val("slot1_loaded", 32'(blk), 32'd2);

    // Three-cycle source gap after word 5.
    do_reset(2);
    core_ready = 4'b1111;
    push_rand_block();
    n = 0;
    while ((pos != 6) && (n < 20)) begin
      step();
      n++;
    end
    check_val("reach_word5", 32'(pos), 32'd6);
    gap = 1'b1;
    run(3);
    gap = 1'b0;
    run(14);
    check_val("gap_block_done", 32'(blk), 32'd1);

    // Five blocks rotate through slots 0,1,2,3,0.
    do_reset(2);
    core_ready = 4'b1111;
    for (int b = 0; b < 5; b++) push_rand_block();
    run(84);
    check_val("five_blocks", 32'(blk), 32'd5);
`ifdef MD5_LOADER_STATS_EN
    check_val("blk_cnt_5", {16'd0, blk_cnt}, 32'd5);
`endif

    // Reset at word 9 of block 1, source still holding data.
    do_reset(2);
    core_ready = 4'b1111;
    for (int b = 0; b < 3; b++) push_rand_block();
    n = 0;
    while (!((blk == 1) && (pos == 10)) && (n < 40)) begin
      step();
      n++;
    end
    check_val("reach_b1_w9", 32'(pos), 32'd10);
    n = fifo.size();
    do_reset(4);
    check_val("no_pop_in_reset", 32'(fifo.size()), 32'(n));
    push_block(32'hABC0, 4'h3);
    run(2);
    drain(100);

    // Randomised gaps, ready flags and block arrivals.
    do_reset(2);
    for (int i = 0; i < 800; i++) begin
      if ((fifo.size() < 32) && ($urandom_range(0, 9) == 0)) push_rand_block();
      gap = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) core_ready = 4'($urandom);
      step();
    end
    gap        = 1'b0;
    core_ready = 4'b1111;
    drain(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
